// File: rtl/vdp18_sched.sv
`default_nettype none
// ============================================================================
// Module   : vdp18_sched  (with package vdp18_pkg)
// Purpose  : VDP raster timing generator and VRAM access scheduler. Owns the
//            horizontal/vertical counters, decodes every 2-pixel memory slot
//            into an access_t, and raises frame / line-compare interrupts.
// Ports    : clk_i, reset_i           - clock, synchronous active-high reset
//            clk_en_5m37_i            - pixel clock enable
//            opmode_i, reg_blank_i,
//            reg_size1_i              - display mode, blank, 16x16 sprites
//            stop_sprite_i            - end sprite fetches for this line
//            line_cmp_i, ie0_i, ie1_i - line compare value, irq enables
//            status_rd_i, line_ack_i  - frame / line flag clear pulses
//            hcount_o, vcount_o       - raster position
//            clk_en_acc_o             - last pixel of each slot
//            access_type_o, spr_idx_o - slot decode, sprite group index
//            vert_active_o, hor_active_o, frame_flag_o, line_flag_o, irq_o
// Revision : 1.0 - initial release
// ============================================================================

package vdp18_pkg;
  typedef enum logic [1:0] {
    OPMODE_GRAPH1 = 2'd0,
    OPMODE_GRAPH2 = 2'd1,
    OPMODE_MULTIC = 2'd2,
    OPMODE_TEXTM  = 2'd3
  } opmode_t;

  // CPU is encoded as zero so the reset state decodes to a CPU slot.
  typedef enum logic [3:0] {
    AC_CPU  = 4'd0,
    AC_PNT  = 4'd1,
    AC_PCT  = 4'd2,
    AC_PGT  = 4'd3,
    AC_STST = 4'd4,
    AC_SATY = 4'd5,
    AC_SATX = 4'd6,
    AC_SATN = 4'd7,
    AC_SATC = 4'd8,
    AC_SPTH = 4'd9,
    AC_SPTL = 4'd10
  } access_t;
endpackage

module vdp18_sched
  import vdp18_pkg::*;
#(
  parameter int H_TOTAL   = 342,
  parameter int V_TOTAL   = 262,
  parameter int V_ACTIVE  = 192,
  parameter int NUM_SPR   = 4,
  parameter int SPR_START = 264,
  localparam int SPR_W    = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clk_en_5m37_i,
  input  opmode_t          opmode_i,
  input  logic             reg_blank_i,
  input  logic             reg_size1_i,
  input  logic             stop_sprite_i,
  input  logic [8:0]       line_cmp_i,
  input  logic             ie0_i,
  input  logic             ie1_i,
  input  logic             status_rd_i,
  input  logic             line_ack_i,
  output logic [8:0]       hcount_o,
  output logic [8:0]       vcount_o,
  output logic             clk_en_acc_o,
  output access_t          access_type_o,
  output logic [SPR_W-1:0] spr_idx_o,
  output logic             vert_active_o,
  output logic             hor_active_o,
  output logic             frame_flag_o,
  output logic             line_flag_o,
  output logic             irq_o
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if ((H_TOTAL % 2) != 0 || H_TOTAL > 512) begin : g_err_htotal
    $error("vdp18_sched: H_TOTAL must be even and <= 512");
  end
  if (V_TOTAL > 512 || V_ACTIVE >= V_TOTAL) begin : g_err_vtotal
    $error("vdp18_sched: V_TOTAL must be <= 512 and exceed V_ACTIVE");
  end
  if ((SPR_START % 2) != 0 || SPR_START < 256) begin : g_err_sprstart
    $error("vdp18_sched: SPR_START must be even and >= 256");
  end
  if (SPR_START + 16*NUM_SPR > H_TOTAL) begin : g_err_sprend
    $error("vdp18_sched: sprite fetch phase exceeds H_TOTAL");
  end

  localparam logic [8:0] c_H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [8:0] c_V_LAST     = 9'(V_TOTAL - 1);
  localparam logic [8:0] c_V_ACT      = 9'(V_ACTIVE);
  localparam logic [8:0] c_V_ACT_LAST = 9'(V_ACTIVE - 1);
  localparam logic [8:0] c_SPR_START  = 9'(SPR_START);
  localparam logic [9:0] c_SPR_END    = 10'(SPR_START + 16*NUM_SPR);

  logic [8:0] r_hcount;
  logic [8:0] r_vcount;
  logic       r_vert_active;
  logic       r_spr_line_act;
  logic [1:0] r_txt_cnt;
  logic       r_frame_flag;
  logic       r_line_flag;

  logic       w_wrap;
  logic [8:0] w_vcount_nxt;
  logic       w_txt_win;
  logic       w_spr_win;
  logic [2:0] w_spr_sub;
  logic       w_frame_set;
  logic       w_line_set;
  access_t    w_access;
  logic [SPR_W-1:0] w_spr_idx;

  assign w_wrap       = (r_hcount == c_H_LAST);
  assign w_vcount_nxt = (r_vcount == c_V_LAST) ? 9'd0 : r_vcount + 9'd1;
  assign w_txt_win    = (r_hcount >= 9'd8) && (r_hcount < 9'd248);
  assign w_spr_win    = (r_hcount >= c_SPR_START) && ({1'b0, r_hcount} < c_SPR_END);
  // Offset into the sprite phase: bits [3:1] pick the slot within a 16-pixel
  // group, bits above 4 pick the group.
  assign w_spr_sub    = 3'((r_hcount - c_SPR_START) >> 1);
  assign w_frame_set  = clk_en_5m37_i && (r_vcount == c_V_ACT_LAST) && w_wrap;
  assign w_line_set   = clk_en_5m37_i && (r_vcount == line_cmp_i) && (r_hcount == 9'd255);

  // --------------------------------------------------------------------------
  // Counters, line-start latches and interrupt flags
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_hcount       <= '0;
      r_vcount       <= '0;
      r_vert_active  <= 1'b0;
      r_spr_line_act <= 1'b0;
      r_txt_cnt      <= '0;
      r_frame_flag   <= 1'b0;
      r_line_flag    <= 1'b0;
    end else begin
      if (clk_en_5m37_i) begin
        if (w_wrap) begin
          r_hcount      <= '0;
          r_vcount      <= w_vcount_nxt;
          r_vert_active <= !reg_blank_i && (w_vcount_nxt < c_V_ACT);
          // Sprite fetches on a line serve the following line, so they run
          // on the line before each active line (including the last line of
          // the frame, which feeds line 0). The wrap load beats a stop.
          r_spr_line_act <= !reg_blank_i && (opmode_i != OPMODE_TEXTM) &&
                            ((w_vcount_nxt == c_V_LAST) || (w_vcount_nxt < c_V_ACT_LAST));
        end else begin
          r_hcount <= r_hcount + 9'd1;
          if (stop_sprite_i) begin
            r_spr_line_act <= 1'b0;
          end
        end

        // Text-mode slot phase: holds 0 across hcount 8..9, then steps once
        // per slot (on the odd pixel) through PNT, CPU, PGT.
        if (r_hcount == 9'd7) begin
          r_txt_cnt <= 2'd0;
        end else if (r_hcount[0]) begin
          r_txt_cnt <= (r_txt_cnt == 2'd2) ? 2'd0 : r_txt_cnt + 2'd1;
        end
      end

      // Clears act on every clock; a coincident set wins.
      if (w_frame_set) begin
        r_frame_flag <= 1'b1;
      end else if (status_rd_i) begin
        r_frame_flag <= 1'b0;
      end

      if (w_line_set) begin
        r_line_flag <= 1'b1;
      end else if (line_ack_i) begin
        r_line_flag <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slot decode (combinational from registered state)
  // --------------------------------------------------------------------------
  always_comb begin
    w_access  = AC_CPU;
    w_spr_idx = '0;
    if (opmode_i == OPMODE_TEXTM) begin
      if (r_vert_active && w_txt_win) begin
        case (r_txt_cnt)
          2'd0:    w_access = AC_PNT;
          2'd2:    w_access = AC_PGT;
          default: w_access = AC_CPU;
        endcase
      end
    end else if (r_vert_active && !r_hcount[8]) begin
      case (r_hcount[2:1])
        2'd0:    w_access = r_spr_line_act ? AC_STST : AC_CPU;
        2'd1:    w_access = AC_PNT;
        2'd2:    w_access = (opmode_i == OPMODE_MULTIC) ? AC_CPU : AC_PCT;
        default: w_access = AC_PGT;
      endcase
    end else if (r_spr_line_act && w_spr_win) begin
      w_spr_idx = SPR_W'((r_hcount - c_SPR_START) >> 4);
      case (w_spr_sub)
        3'd0:    w_access = AC_SATY;
        3'd1:    w_access = AC_SATX;
        3'd2:    w_access = AC_SATN;
        3'd3:    w_access = AC_SATC;
        3'd4:    w_access = AC_SPTH;
        3'd5:    w_access = reg_size1_i ? AC_SPTL : AC_CPU;
        default: w_access = AC_CPU;
      endcase
    end
  end

  always_comb begin
    hor_active_o = 1'b0;
    if (!reg_blank_i) begin
      hor_active_o = (opmode_i == OPMODE_TEXTM) ? w_txt_win : !r_hcount[8];
    end
  end

  assign hcount_o      = r_hcount;
  assign vcount_o      = r_vcount;
  assign clk_en_acc_o  = clk_en_5m37_i & r_hcount[0];
  assign access_type_o = w_access;
  assign spr_idx_o     = w_spr_idx;
  assign vert_active_o = r_vert_active;
  assign frame_flag_o  = r_frame_flag;
  assign line_flag_o   = r_line_flag;
  assign irq_o         = (r_frame_flag & ie0_i) | (r_line_flag & ie1_i);

endmodule
`default_nettype wire

// File: tb/tb_vdp18_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp18_sched
// Purpose  : Directed self-checking bench for vdp18_sched. A default-parameter
//            instance covers reset, counters and slot decode; a second
//            instance (212 active / 313 total lines) shares the inputs and
//            covers the extended-timing interrupt behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp18_sched;
  import vdp18_pkg::*;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic       reset_i, clk_en, reg_blank, reg_size1, stop_sprite;
  logic       ie0, ie1, status_rd, line_ack;
  logic [8:0] line_cmp;
  opmode_t    opmode;

  logic [8:0] hcount, vcount, hcount_e, vcount_e;
  logic       clk_en_acc, vert_active, hor_active, frame_flag, line_flag, irq;
  logic       clk_en_acc_e, vert_active_e, hor_active_e, frame_flag_e, line_flag_e, irq_e;
  access_t    access_type, access_type_e;
  logic [1:0] spr_idx, spr_idx_e;

  int n_cmp  = 0;
  int n_fail = 0;

  vdp18_sched dut (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_5m37_i(clk_en), .opmode_i(opmode),
    .reg_blank_i(reg_blank), .reg_size1_i(reg_size1), .stop_sprite_i(stop_sprite),
    .line_cmp_i(line_cmp), .ie0_i(ie0), .ie1_i(ie1), .status_rd_i(status_rd),
    .line_ack_i(line_ack), .hcount_o(hcount), .vcount_o(vcount),
    .clk_en_acc_o(clk_en_acc), .access_type_o(access_type), .spr_idx_o(spr_idx),
    .vert_active_o(vert_active), .hor_active_o(hor_active),
    .frame_flag_o(frame_flag), .line_flag_o(line_flag), .irq_o(irq)
  );

  vdp18_sched #(.V_ACTIVE(212), .V_TOTAL(313)) dut_ext (
    .clk_i(clk_i), .reset_i(reset_i), .clk_en_5m37_i(clk_en), .opmode_i(opmode),
    .reg_blank_i(reg_blank), .reg_size1_i(reg_size1), .stop_sprite_i(stop_sprite),
    .line_cmp_i(line_cmp), .ie0_i(ie0), .ie1_i(ie1), .status_rd_i(status_rd),
    .line_ack_i(line_ack), .hcount_o(hcount_e), .vcount_o(vcount_e),
    .clk_en_acc_o(clk_en_acc_e), .access_type_o(access_type_e), .spr_idx_o(spr_idx_e),
    .vert_active_o(vert_active_e), .hor_active_o(hor_active_e),
    .frame_flag_o(frame_flag_e), .line_flag_o(line_flag_e), .irq_o(irq_e)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Advance until the chosen instance sits at (h, v); an expired budget is
  // reported as a failed comparison.
  task automatic wait_pos(input logic [8:0] h, input logic [8:0] v, input bit use_ext, input int budget);
    int n = 0;
    while (!(use_ext ? (hcount_e == h && vcount_e == v) : (hcount == h && vcount == v))) begin
      if (n >= budget) begin
        n_cmp++; n_fail++;
        $display("FAIL wait_pos: h=%0d v=%0d not reached, now h=%0d v=%0d", h, v,
                 use_ext ? hcount_e : hcount, use_ext ? vcount_e : vcount);
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    n_cmp++; if (hcount !== 9'd0) begin n_fail++; $display("FAIL rst_hcount: got %0d want 0", hcount); end
    n_cmp++; if (vcount !== 9'd0) begin n_fail++; $display("FAIL rst_vcount: got %0d want 0", vcount); end
    n_cmp++; if (access_type !== AC_CPU) begin n_fail++; $display("FAIL rst_access: got %0d want %0d", access_type, AC_CPU); end
    n_cmp++; if (spr_idx !== 2'd0) begin n_fail++; $display("FAIL rst_spr_idx: got %0d want 0", spr_idx); end
    n_cmp++; if (vert_active !== 1'b0) begin n_fail++; $display("FAIL rst_vert_active: got %b want 0", vert_active); end
    n_cmp++; if ({frame_flag, line_flag, irq} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {frame_flag, line_flag, irq}); end
    n_cmp++; if (clk_en_acc !== 1'b0) begin n_fail++; $display("FAIL rst_clk_en_acc: got %b want 0", clk_en_acc); end
    reset_i = 1'b0;
    tick();
    n_cmp++; if (hcount !== 9'd1) begin n_fail++; $display("FAIL rst_release_hcount: got %0d want 1", hcount); end
    // Mid-frame reset: run into line 1, then abort.
    repeat (391) tick();
    n_cmp++; if ({vcount, hcount} !== {9'd1, 9'd50}) begin n_fail++; $display("FAIL pre_midreset_pos: got v=%0d h=%0d want v=1 h=50", vcount, hcount); end
    reset_i = 1'b1;
    tick();
    n_cmp++; if ({vcount, hcount, vert_active} !== {9'd0, 9'd0, 1'b0}) begin n_fail++; $display("FAIL midreset_state: got v=%0d h=%0d va=%b want 0 0 0", vcount, hcount, vert_active); end
    reset_i = 1'b0;
    tick();
    n_cmp++; if (hcount !== 9'd1) begin n_fail++; $display("FAIL midreset_release_hcount: got %0d want 1", hcount); end
  endtask

  task automatic test_first_line();
    repeat (340) tick();
    n_cmp++; if ({vcount, hcount} !== {9'd0, 9'd341}) begin n_fail++; $display("FAIL line0_end_pos: got v=%0d h=%0d want v=0 h=341", vcount, hcount); end
    n_cmp++; if (vert_active !== 1'b0) begin n_fail++; $display("FAIL line0_vert_active: got %b want 0", vert_active); end
    // Counters must hold with the enable low.
    clk_en = 1'b0;
    tick();
    n_cmp++; if (hcount !== 9'd341 || clk_en_acc !== 1'b0) begin n_fail++; $display("FAIL clk_en_hold: got h=%0d acc=%b want h=341 acc=0", hcount, clk_en_acc); end
    clk_en = 1'b1;
    #1;
    n_cmp++; if (clk_en_acc !== 1'b1) begin n_fail++; $display("FAIL clk_en_acc_odd: got %b want 1", clk_en_acc); end
    tick();
    n_cmp++; if ({vcount, hcount} !== {9'd1, 9'd0}) begin n_fail++; $display("FAIL wrap_pos: got v=%0d h=%0d want v=1 h=0", vcount, hcount); end
    n_cmp++; if (vert_active !== 1'b1) begin n_fail++; $display("FAIL line1_vert_active: got %b want 1", vert_active); end
    repeat (342) tick();
    n_cmp++; if ({vcount, hcount} !== {9'd2, 9'd0}) begin n_fail++; $display("FAIL line2_pos: got v=%0d h=%0d want v=2 h=0", vcount, hcount); end
  endtask

  task automatic test_graph2();
    access_t exp_g2[8];
    access_t exp_mc[8];
    exp_g2 = '{AC_STST, AC_STST, AC_PNT, AC_PNT, AC_PCT, AC_PCT, AC_PGT, AC_PGT};
    exp_mc = '{AC_STST, AC_STST, AC_PNT, AC_PNT, AC_CPU, AC_CPU, AC_PGT, AC_PGT};
    wait_pos(9'd0, 9'd10, 1'b0, 5000);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (access_type !== exp_g2[i]) begin n_fail++; $display("FAIL g2_slot h=%0d: got %0d want %0d", i, access_type, exp_g2[i]); end
      n_cmp++; if (clk_en_acc !== i[0]) begin n_fail++; $display("FAIL g2_acc h=%0d: got %b want %b", i, clk_en_acc, i[0]); end
      tick();
    end
    opmode = OPMODE_MULTIC;
    wait_pos(9'd16, 9'd10, 1'b0, 100);
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (access_type !== exp_mc[i]) begin n_fail++; $display("FAIL mc_slot h=%0d: got %0d want %0d", 16 + i, access_type, exp_mc[i]); end
      tick();
    end
    opmode = OPMODE_GRAPH2;
  endtask

  task automatic test_sprite();
    access_t exp_spr[8];
    exp_spr = '{AC_SATY, AC_SATX, AC_SATN, AC_SATC, AC_SPTH, AC_CPU, AC_CPU, AC_CPU};
    wait_pos(9'd264, 9'd10, 1'b0, 1000);
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if (access_type !== exp_spr[(i / 2) % 8]) begin n_fail++; $display("FAIL spr_slot h=%0d: got %0d want %0d", 264 + i, access_type, exp_spr[(i / 2) % 8]); end
      n_cmp++; if (spr_idx !== 2'(i / 16)) begin n_fail++; $display("FAIL spr_idx h=%0d: got %0d want %0d", 264 + i, spr_idx, i / 16); end
      tick();
    end
    n_cmp++; if (access_type !== AC_CPU || spr_idx !== 2'd0) begin n_fail++; $display("FAIL spr_after h=328: got acc=%0d idx=%0d want 0 0", access_type, spr_idx); end
    n_cmp++; if (hor_active !== 1'b0) begin n_fail++; $display("FAIL hor_active_328: got %b want 0", hor_active); end
  endtask

  task automatic test_blank();
    wait_pos(9'd100, 9'd11, 1'b0, 1000);
    reg_blank = 1'b1;
    #1;
    n_cmp++; if (hor_active !== 1'b0) begin n_fail++; $display("FAIL blank_hor_active: got %b want 0", hor_active); end
    tick();
    n_cmp++; if (vert_active !== 1'b1) begin n_fail++; $display("FAIL blank_vert_active_holds: got %b want 1", vert_active); end
    reg_blank = 1'b0;
    #1;
    n_cmp++; if (hor_active !== 1'b1) begin n_fail++; $display("FAIL unblank_hor_active: got %b want 1", hor_active); end
  endtask

  task automatic test_sprite_stop();
    wait_pos(9'd274, 9'd11, 1'b0, 1000);
    reg_size1 = 1'b1;
    #1;
    n_cmp++; if (access_type !== AC_SPTL) begin n_fail++; $display("FAIL size1_sptl: got %0d want %0d", access_type, AC_SPTL); end
    reg_size1 = 1'b0;
    wait_pos(9'd279, 9'd11, 1'b0, 100);
    stop_sprite = 1'b1;
    tick();
    stop_sprite = 1'b0;
    for (int h = 280; h < 342; h++) begin
      n_cmp++; if (access_type !== AC_CPU) begin n_fail++; $display("FAIL stop_cpu h=%0d: got %0d want %0d", h, access_type, AC_CPU); end
      tick();
    end
    n_cmp++; if ({vcount, hcount} !== {9'd12, 9'd0} || access_type !== AC_STST) begin n_fail++; $display("FAIL stop_next_line: got v=%0d h=%0d acc=%0d want 12 0 %0d", vcount, hcount, access_type, AC_STST); end
  endtask

  task automatic test_text();
    access_t exp_tx[6];
    int pnt = 0;
    exp_tx = '{AC_PNT, AC_PNT, AC_CPU, AC_CPU, AC_PGT, AC_PGT};
    opmode = OPMODE_TEXTM;
    wait_pos(9'd7, 9'd12, 1'b0, 100);
    n_cmp++; if (hor_active !== 1'b0 || access_type !== AC_CPU) begin n_fail++; $display("FAIL text_h7: got ha=%b acc=%0d want 0 0", hor_active, access_type); end
    tick();
    n_cmp++; if (hor_active !== 1'b1) begin n_fail++; $display("FAIL text_h8_hor_active: got %b want 1", hor_active); end
    for (int h = 8; h < 248; h++) begin
      if (h < 14) begin
        n_cmp++; if (access_type !== exp_tx[h - 8]) begin n_fail++; $display("FAIL text_slot h=%0d: got %0d want %0d", h, access_type, exp_tx[h - 8]); end
      end
      if (access_type == AC_PNT && hcount[0] == 1'b0) pnt++;
      tick();
    end
    n_cmp++; if (pnt !== 40) begin n_fail++; $display("FAIL text_pnt_count: got %0d want 40", pnt); end
    n_cmp++; if (hor_active !== 1'b0 || access_type !== AC_CPU) begin n_fail++; $display("FAIL text_h248: got ha=%b acc=%0d want 0 0", hor_active, access_type); end
    // Line 13 was latched while in text mode, so no sprite work on it.
    wait_pos(9'd0, 9'd13, 1'b0, 1000);
    opmode = OPMODE_GRAPH2;
    #1;
    n_cmp++; if (access_type !== AC_CPU) begin n_fail++; $display("FAIL after_text_no_stst: got %0d want %0d", access_type, AC_CPU); end
  endtask

  task automatic test_line_irq();
    ie1 = 1'b1;
    wait_pos(9'd255, 9'd100, 1'b1, 40000);
    n_cmp++; if (line_flag_e !== 1'b0) begin n_fail++; $display("FAIL line_flag_early: got %b want 0", line_flag_e); end
    tick();
    n_cmp++; if (line_flag_e !== 1'b1 || irq_e !== 1'b1) begin n_fail++; $display("FAIL line_flag_set: got lf=%b irq=%b want 1 1", line_flag_e, irq_e); end
    n_cmp++; if (line_flag !== 1'b1) begin n_fail++; $display("FAIL line_flag_set_default: got %b want 1", line_flag); end
    // Acknowledge works without a pixel enable.
    clk_en = 1'b0;
    line_ack = 1'b1;
    tick();
    line_ack = 1'b0;
    clk_en = 1'b1;
    n_cmp++; if (line_flag_e !== 1'b0 || irq_e !== 1'b0) begin n_fail++; $display("FAIL line_ack_clear: got lf=%b irq=%b want 0 0", line_flag_e, irq_e); end
    ie1 = 1'b0;
  endtask

  task automatic test_frame_irq();
    ie0 = 1'b1;
    wait_pos(9'd341, 9'd191, 1'b0, 40000);
    n_cmp++; if (frame_flag !== 1'b0) begin n_fail++; $display("FAIL frame_flag_early: got %b want 0", frame_flag); end
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
    n_cmp++; if (frame_flag !== 1'b1 || irq !== 1'b1) begin n_fail++; $display("FAIL frame_set_wins: got ff=%b irq=%b want 1 1", frame_flag, irq); end
    n_cmp++; if (vcount !== 9'd192 || vert_active !== 1'b0) begin n_fail++; $display("FAIL frame_line192: got v=%0d va=%b want 192 0", vcount, vert_active); end
    n_cmp++; if (vert_active_e !== 1'b1 || frame_flag_e !== 1'b0) begin n_fail++; $display("FAIL ext_line192: got va=%b ff=%b want 1 0", vert_active_e, frame_flag_e); end
    repeat (3) tick();
    n_cmp++; if (frame_flag !== 1'b1) begin n_fail++; $display("FAIL frame_flag_holds: got %b want 1", frame_flag); end
    status_rd = 1'b1;
    tick();
    status_rd = 1'b0;
    n_cmp++; if (frame_flag !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL status_rd_clear: got ff=%b irq=%b want 0 0", frame_flag, irq); end
    wait_pos(9'd341, 9'd211, 1'b1, 8000);
    n_cmp++; if (frame_flag_e !== 1'b0) begin n_fail++; $display("FAIL ext_frame_early: got %b want 0", frame_flag_e); end
    tick();
    n_cmp++; if (frame_flag_e !== 1'b1 || irq_e !== 1'b1 || vcount_e !== 9'd212) begin n_fail++; $display("FAIL ext_frame_set: got ff=%b irq=%b v=%0d want 1 1 212", frame_flag_e, irq_e, vcount_e); end
  endtask

  initial begin
    reset_i     = 1'b1;
    clk_en      = 1'b1;
    opmode      = OPMODE_GRAPH2;
    reg_blank   = 1'b0;
    reg_size1   = 1'b0;
    stop_sprite = 1'b0;
    line_cmp    = 9'd100;
    ie0         = 1'b0;
    ie1         = 1'b0;
    status_rd   = 1'b0;
    line_ack    = 1'b0;

    test_reset();
    test_first_line();
    test_graph2();
    test_sprite();
    test_blank();
    test_sprite_stop();
    test_text();
    test_line_irq();
    test_frame_irq();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
